// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents: LCR bit positions, word-length encoding, TX FSM state type, bit timing constants
// and the parity helper used by the serializer.
package uart_pkg;

    // LCR bit positions ([1:0] is the word-length select)
    localparam int unsigned LcrStb = 2;
    localparam int unsigned LcrPen = 3;
    localparam int unsigned LcrEps = 4;
    localparam int unsigned LcrSp  = 5;
    localparam int unsigned LcrBc  = 6;

    // WLS encoding for 5-bit words; the only length that changes stop-bit timing
    localparam logic [1:0] Wls5 = 2'd0;

    localparam int unsigned TicksPerBit = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } tx_state_e;

    // data_xor is the XOR of all transmitted data bits
    function automatic logic parity_bit(input logic data_xor, input logic eps, input logic sp);
        if (sp) begin
            return ~eps;
        end
        return eps ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports: clk_i, rst_i (sync, active high), push_i/pop_i (pre-qualified by the caller),
// clr_i (flush, wins over push/pop), data_i, data_o (head entry), count_o (occupancy),
// ready_o (registered "not full", low during reset).
module uart_tx_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Aw    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  logic [7:0]    data_i,
    output logic [7:0]    data_o,
    output logic [Aw:0]   count_o,
    output logic          ready_o
);

    localparam logic [Aw:0] DepthCnt = Depth[Aw:0];

    logic [7:0]    mem_q [Depth];
    logic [Aw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Aw:0]   count_q, count_d;
    logic          ready_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + Aw'(1);
            if (pop_i)  rptr_d = rptr_q + Aw'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + (Aw + 1)'(1);
                2'b01:   count_d = count_q - (Aw + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ready_q <= (count_d < DepthCnt);
            if (push_i && !clr_i) mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: buffers bytes and frames them (start, 5-8 data LSB first, optional parity,
// 1/1.5/2 stop) on stx_o, paced by the 16x baud enable.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single
// holding register feeds the shifter.
// Ports: clk_i, rst_i (sync, active high), enable_i (16x tick), lcr_i (line control),
// tx_data_i/tx_valid_i/tx_ready_o (byte write handshake), tx_clr_i (flush pending bytes),
// stx_o (serial out, idle high), thr_empty_o (THRE), tx_idle_o (TEMT),
// fifo_count_o (pending bytes).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned Tp         = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [7:0]         lcr_i,
    input  logic [7:0]         tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    input  logic               tx_clr_i,
    output logic               stx_o,
    output logic               thr_empty_o,
    output logic               tx_idle_o,
    output logic [FIFO_AW:0]   fifo_count_o
);

    localparam logic [3:0] BitLast  = 4'(TicksPerBit - 1);
    localparam logic [3:0] HalfLast = 4'(TicksPerBit / 2 - 1);

    logic       push, pop, pending, thr_empty;
    logic [7:0] head_data;

    assign push    = tx_valid_i && tx_ready_o && !tx_clr_i;
    assign pending = !thr_empty && !tx_clr_i;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .Depth (FIFO_DEPTH),
        .Aw    (FIFO_AW)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (tx_clr_i),
        .data_i  (tx_data_i),
        .data_o  (head_data),
        .count_o (fifo_count_o),
        .ready_o (tx_ready_o)
    );
    assign thr_empty = (fifo_count_o == '0);
`else
    logic [7:0] hold_q;
    logic       hold_valid_q, hold_valid_d, hold_ready_q;

    // push and pop are mutually exclusive: push needs an empty register, pop a full one
    always_comb begin
        hold_valid_d = hold_valid_q;
        if (tx_clr_i)  hold_valid_d = 1'b0;
        else if (push) hold_valid_d = 1'b1;
        else if (pop)  hold_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_ready_q <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_ready_q <= !hold_valid_d;
            if (push) hold_q <= tx_data_i;
        end
    end

    assign head_data    = hold_q;
    assign thr_empty    = !hold_valid_q;
    assign tx_ready_o   = hold_ready_q;
    assign fifo_count_o = {{FIFO_AW{1'b0}}, hold_valid_q};
`endif

    tx_state_e  state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [5:0] lcr_q, lcr_d;
    logic       stx_q, stx_d, line_bit;
    logic       load, frame_end;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        lcr_d     = lcr_q;
        load      = 1'b0;
        frame_end = 1'b0;
        if (enable_i) begin
            tick_d = tick_q + 4'd1;
            unique case (state_q)
                StIdle: begin
                    tick_d = '0;
                    load   = pending;
                end
                StStart: begin
                    if (tick_q == BitLast) begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
                StData: begin
                    if (tick_q == BitLast) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        par_d   = par_q ^ shift_q[0];
                        // last data bit index is 4 + WLS
                        if (bit_q == {1'b1, lcr_q[1:0]}) begin
                            state_d = lcr_q[LcrPen] ? StParity : StStop1;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (tick_q == BitLast) state_d = StStop1;
                end
                StStop1: begin
                    if (tick_q == BitLast) begin
                        if (lcr_q[LcrStb]) state_d = StStop2;
                        else               frame_end = 1'b1;
                    end
                end
                StStop2: begin
                    // 5-bit words get 1.5 stop bits
                    if (tick_q == ((lcr_q[1:0] == Wls5) ? HalfLast : BitLast)) frame_end = 1'b1;
                end
                default: state_d = StIdle;
            endcase
            if (frame_end) begin
                tick_d  = '0;
                state_d = StIdle;
                load    = pending;
            end
            if (load) begin
                state_d = StStart;
                tick_d  = '0;
                shift_d = head_data;
                par_d   = 1'b0;
                lcr_d   = lcr_i[5:0];
            end
        end
    end

    assign pop = load;

    // Line level for the state being entered, so stx_o changes with the state register
    always_comb begin
        line_bit = 1'b1;
        unique case (state_d)
            StStart:  line_bit = 1'b0;
            StData:   line_bit = shift_d[0];
            StParity: line_bit = parity_bit(par_d, lcr_d[LcrEps], lcr_d[LcrSp]);
            default:  line_bit = 1'b1;
        endcase
    end

    // Break uses the live LCR, not the per-frame copy
    assign stx_d = lcr_i[LcrBc] ? 1'b0 : line_bit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            lcr_q   <= '0;
            stx_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            lcr_q   <= lcr_d;
            stx_q   <= stx_d;
        end
    end

    assign stx_o       = stx_q;
    assign thr_empty_o = thr_empty;
    assign tx_idle_o   = thr_empty && (state_q == StIdle);

    logic unused_cfg;
    assign unused_cfg = ^{Tp, FIFO_DEPTH, lcr_i[7]};

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b1;
    logic [7:0] lcr_i = 8'h03;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_clr_i = 1'b0;
    logic       tx_ready_o, stx_o, thr_empty_o, tx_idle_o;
    logic [4:0] fifo_count_o;

    int n_checks = 0;
    int n_fail = 0;

    // per-frame schedule knobs, indexed by sample number within the frame
    int         bc_from = -1;
    int         bc_to = -1;
    int         push_at = -1;
    logic [7:0] push_data = 8'h00;
    logic [7:0] lcr_mid = 8'h03;
    bit         chk_idle = 1'b1;

    always #5 clk = ~clk;

    uart_tx_serializer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .lcr_i        (lcr_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .tx_clr_i     (tx_clr_i),
        .stx_o        (stx_o),
        .thr_empty_o  (thr_empty_o),
        .tx_idle_o    (tx_idle_o),
        .fifo_count_o (fifo_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] data, input logic [7:0] lcr);
        int n;
        n = 0;
        while (!tx_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", tx_ready_o, 1);
        lcr_i      = lcr;
        tx_data_i  = data;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    // bits: frame LSB first (start, data, parity, stops); last bit lasts last_ticks
    task automatic run_frame(input logic [11:0] bits, input int nbits, input int last_ticks,
                             input string tag);
        int   s, good, len;
        logic e;
        s = 0;
        for (int b = 0; b < nbits; b++) begin
            len  = (b == nbits - 1) ? last_ticks : 16;
            good = 0;
            for (int t = 0; t < len; t++) begin
                @(negedge clk);
                tx_valid_i = 1'b0;
                e = (s > bc_from && s <= bc_to) ? 1'b0 : bits[b];
                if (stx_o === e) good++;
                if (s == 0) lcr_i = lcr_mid;
                if (s == bc_from) lcr_i[6] = 1'b1;
                if (s == bc_to) lcr_i[6] = 1'b0;
                if (s == push_at) begin
                    tx_data_i  = push_data;
                    tx_valid_i = 1'b1;
                end
                s++;
            end
            check($sformatf("%s_bit%0d", tag, b), good, len);
        end
        if (chk_idle) begin
            check({tag, "_busy_last"}, tx_idle_o, 0);
            @(negedge clk);
            check({tag, "_idle"}, tx_idle_o, 1);
            check({tag, "_stx_idle"}, stx_o, 1);
        end
    endtask

    initial begin
        int n;
        int good;

        // reset
        repeat (3) @(negedge clk);
        check("rst_stx", stx_o, 1);
        check("rst_ready", tx_ready_o, 0);
        check("rst_thre", thr_empty_o, 1);
        check("rst_idle", tx_idle_o, 1);
        check("rst_count", fifo_count_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready_o, 1);

        // 8N1 0x55
        send(8'h55, 8'h03);
        lcr_mid = 8'h03;
        run_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10, 16, "8n1");

        // 7E1 0x41, parity 0
        send(8'h41, 8'h1A);
        lcr_mid = 8'h1A;
        run_frame({2'b00, 1'b1, 1'b0, 7'h41, 1'b0}, 10, 16, "7e1");

        // 7O1 0xC1 (bit 7 ignored), parity 1
        send(8'hC1, 8'h0A);
        lcr_mid = 8'h0A;
        run_frame({2'b00, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 16, "7o1");

        // 5 bits, 1.5 stop
        send(8'h1F, 8'h04);
        lcr_mid = 8'h04;
        run_frame({4'b0000, 2'b11, 5'h1F, 1'b0}, 8, 8, "5n15");

        // 8N2
        send(8'hA3, 8'h07);
        lcr_mid = 8'h07;
        run_frame({1'b0, 2'b11, 8'hA3, 1'b0}, 11, 16, "8n2");

        // stick parity with EPS=1 -> parity bit 0 (even parity would give 1)
        send(8'h01, 8'h3B);
        lcr_mid = 8'h3B;
        run_frame({1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 16, "stick");

        // LCR changed to 5 bits after latch, plus break over samples 41..60
        send(8'h55, 8'h03);
        lcr_mid = 8'h00;
        bc_from = 40;
        bc_to   = 60;
        run_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10, 16, "brk");
        bc_from = -1;
        bc_to   = -1;

        // back-to-back: second byte written mid-frame starts with no idle gap
        send(8'h55, 8'h03);
        lcr_mid   = 8'h03;
        push_at   = 20;
        push_data = 8'h0F;
        chk_idle  = 1'b0;
        run_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10, 16, "b2b_a");
        push_at  = -1;
        chk_idle = 1'b1;
        run_frame({2'b00, 1'b1, 8'h0F, 1'b0}, 10, 16, "b2b_b");

        // reset during parity bit of 7E1 0x41
        send(8'h41, 8'h1A);
        repeat (130) @(negedge clk);
        check("par_before_rst", stx_o, 0);
        check("busy_before_rst", tx_idle_o, 0);
        rst_i = 1'b1;
        @(negedge clk);
        check("midrst_stx", stx_o, 1);
        check("midrst_idle", tx_idle_o, 1);
        check("midrst_ready", tx_ready_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("postrst_ready", tx_ready_o, 1);
        check("postrst_stx", stx_o, 1);

        // holding-register full, overflow and flush
        send(8'h3C, 8'h03);
        check("hold_count1", fifo_count_o, 1);
        check("hold_ready0", tx_ready_o, 0);
        check("hold_thre0", thr_empty_o, 0);
        @(negedge clk);
        check("pop_count0", fifo_count_o, 0);
        check("pop_ready1", tx_ready_o, 1);
        check("start_stx", stx_o, 0);
        tx_data_i  = 8'h99;
        tx_valid_i = 1'b1;
        tx_clr_i   = 1'b1;
        @(negedge clk);
        tx_clr_i = 1'b0;
        check("clr_push_drop", fifo_count_o, 0);
        check("clr_push_thre", thr_empty_o, 1);
        tx_data_i = 8'h5A;
        @(negedge clk);
        tx_data_i = 8'h77;
        @(negedge clk);
        tx_valid_i = 1'b0;
        check("full_count", fifo_count_o, 1);
        check("full_ready", tx_ready_o, 0);
        tx_clr_i = 1'b1;
        @(negedge clk);
        tx_clr_i = 1'b0;
        check("flush_count", fifo_count_o, 0);
        check("flush_ready", tx_ready_o, 1);
        check("flush_thre", thr_empty_o, 1);
        check("flush_busy", tx_idle_o, 0);
        n = 0;
        while (!tx_idle_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("flush_frame_len", n, 156);
        good = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stx_o === 1'b1 && tx_idle_o === 1'b1) good++;
        end
        check("no_frame_after_flush", good, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
